// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states and
// the request legality check applied when a request is accepted.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_DATA,
    WRITE,
    RESP
  } lsu_state_t;

  // High when the request is misaligned, outside the RAM, or of illegal size.
  function automatic logic lsu_req_error(input logic [1:0]  size,
                                         input logic [31:0] addr,
                                         input int unsigned addr_width);
    logic range_err;
    range_err = (addr >> (addr_width + 2)) != 32'd0;
    case (size)
      SZ_BYTE: return range_err;
      SZ_HALF: return range_err | addr[0];
      SZ_WORD: return range_err | (addr[1:0] != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response channel between the MEM stage (master) and the LSU (slave).
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/lsu_lane_mux.sv
// Byte-lane steering: extracts and extends load data from a RAM word, and
// merges sub-word store data into the old word for read-modify-write.
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic        sign_fill;

  always_comb begin
    lane_byte = old_word[{offset, 3'b000} +: 8];
    lane_half = old_word[{offset[1], 4'b0000} +: 16];
    sign_fill = 1'b0;
    load_data = old_word;
    case (size)
      SZ_BYTE: begin
        sign_fill = ~is_unsigned & lane_byte[7];
        load_data = {{24{sign_fill}}, lane_byte};
      end
      SZ_HALF: begin
        sign_fill = ~is_unsigned & lane_half[15];
        load_data = {{16{sign_fill}}, lane_half};
      end
      default: load_data = old_word;
    endcase
  end

  always_comb begin
    store_word = old_word;
    case (size)
      SZ_BYTE: store_word[{offset, 3'b000} +: 8]    = new_data[7:0];
      SZ_HALF: store_word[{offset[1], 4'b0000} +: 16] = new_data[15:0];
      default: store_word = new_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store in flight, sub-word stores done as
// read-modify-write against a word-wide synchronous RAM.
//
// state    | meaning
// IDLE     | ready for a request
// RD_ISSUE | RAM read address presented
// RD_DATA  | mem_q valid; load result or merged store word registered
// WRITE    | mem_we high for one cycle
// RESP     | resp_valid pulse
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  lsu_if.slave                  bus,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  lsu_state_t state, next_state;

  logic                  accept;
  logic                  req_err;
  logic                  write_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic [1:0]            offset_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [31:0]           rdata_q;
  logic                  error_q;
  logic                  mem_we_q;
  logic [31:0]           load_data;
  logic [31:0]           store_word;

  lsu_lane_mux u_lane_mux (
    .size        (size_q),
    .offset      (offset_q),
    .is_unsigned (unsigned_q),
    .old_word    (mem_q),
    .new_data    (data_q),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    req_err    = lsu_req_error(bus.req_size, bus.req_addr, ADDR_WIDTH);
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (req_err)
            next_state = RESP;
          else if (bus.req_write && bus.req_size == SZ_WORD)
            next_state = WRITE;
          else
            next_state = RD_ISSUE;
        end
      end
      RD_ISSUE: next_state = RD_DATA;
      RD_DATA:  next_state = write_q ? WRITE : RESP;
      WRITE:    next_state = RESP;
      RESP:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_q    <= 1'b0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      offset_q   <= 2'b00;
      addr_q     <= '0;
      data_q     <= '0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
      mem_we_q   <= 1'b0;
    end else begin
      mem_we_q <= (next_state == WRITE);
      if (accept) begin
        write_q    <= bus.req_write;
        size_q     <= bus.req_size;
        unsigned_q <= bus.req_unsigned;
        offset_q   <= bus.req_addr[1:0];
        error_q    <= req_err;
        rdata_q    <= '0;
        // Rejected requests leave the RAM-facing registers untouched.
        if (!req_err) begin
          addr_q <= bus.req_addr[ADDR_WIDTH+1:2];
          data_q <= bus.req_wdata;
        end
      end
      if (state == RD_DATA) begin
        if (write_q) data_q  <= store_word;
        else         rdata_q <= load_data;
      end
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = error_q;

  assign mem_read_addr  = addr_q;
  assign mem_write_addr = addr_q;
  assign mem_data       = data_q;
  assign mem_we         = mem_we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-built multi-cycle
// sequences, then random traffic against a byte-array reference model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  lsu_if bus ();

  logic [14:0] mem_read_addr;
  logic [14:0] mem_write_addr;
  logic [31:0] mem_data;
  logic        mem_we;
  logic [31:0] mem_q = 32'h0;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(15)) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .mem_read_addr  (mem_read_addr),
    .mem_write_addr (mem_write_addr),
    .mem_data       (mem_data),
    .mem_we         (mem_we),
    .mem_q          (mem_q)
  );

  // Synchronous RAM with a bench-side preload port.
  logic [31:0] ram [0:32767] = '{default: 32'h0};
  logic        poke_en   = 1'b0;
  logic [14:0] poke_addr = 15'h0;
  logic [31:0] poke_data = 32'h0;

  always @(posedge clock) begin
    if (poke_en)     ram[poke_addr] <= poke_data;
    else if (mem_we) ram[mem_write_addr] <= mem_data;
    mem_q <= ram[mem_read_addr];
  end

  // Reference memory, byte addressed.
  logic [7:0] shadow [0:131071] = '{default: 8'h0};

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic poke(input logic [31:0] byte_addr, input logic [31:0] val);
    int base;
    @(negedge clock);
    poke_en   = 1'b1;
    poke_addr = byte_addr[16:2];
    poke_data = val;
    @(negedge clock);
    poke_en = 1'b0;
    base = int'(byte_addr) & ~3;
    for (int i = 0; i < 4; i++) shadow[base + i] = val[8*i +: 8];
  endtask

  task automatic model(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic exp_err, output logic [31:0] exp_rd,
                       output int exp_lat, output logic [31:0] exp_word);
    int n;
    int base;
    logic [31:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    exp_err  = (sz == 2'd3) || ((a % n) != 0) || (a >= 32'h0002_0000);
    exp_rd   = 32'h0;
    exp_word = 32'h0;
    exp_lat  = 1;
    if (!exp_err) begin
      base = int'(a);
      if (w) begin
        for (int i = 0; i < n; i++) shadow[base + i] = wd[8*i +: 8];
        for (int i = 0; i < 4; i++) exp_word[8*i +: 8] = shadow[(base & ~3) + i];
        exp_lat = (n == 4) ? 2 : 4;
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = shadow[base + i];
        if (!u && n < 4 && v[8*n-1])
          for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        exp_rd  = v;
        exp_lat = 3;
      end
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid    = v;
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
  endtask

  // Issue one request and observe 8 cycles after acceptance; fields are
  // scrambled after acceptance so they must have been captured.
  task automatic run_and_check(input string name, input logic w, input logic [1:0] sz,
                               input logic u, input logic [31:0] a, input logic [31:0] wd,
                               input logic exp_err, input logic [31:0] exp_rd,
                               input int exp_lat, input logic [31:0] exp_word);
    int lat, we_cnt, we_cyc, ready_seen, extra;
    logic [31:0] rd, wdat, r;
    logic er;
    logic [14:0] wa;
    lat = -1; we_cnt = 0; we_cyc = -1; ready_seen = 0; extra = 0;
    rd = 32'h0; wdat = 32'h0; er = 1'b0; wa = 15'h0;
    @(negedge clock);
    drive(1'b1, w, sz, u, a, wd);
    @(posedge clock);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      r = $urandom;
      drive(1'b0, r[2], r[1:0], r[3], $urandom, $urandom);
      if (lat < 0) begin
        if (bus.req_ready) ready_seen++;
        if (mem_we) begin we_cnt++; we_cyc = c; wa = mem_write_addr; wdat = mem_data; end
        if (bus.resp_valid) begin lat = c; rd = bus.resp_rdata; er = bus.resp_error; end
      end else if (bus.resp_valid || mem_we) begin
        extra++;
      end
    end
    check($sformatf("%s error", name), 32'(er), 32'(exp_err));
    check($sformatf("%s rdata", name), rd, exp_rd);
    check($sformatf("%s latency", name), 32'(lat), 32'(exp_lat));
    check($sformatf("%s ready while busy", name), 32'(ready_seen), 32'd0);
    check($sformatf("%s stray pulses", name), 32'(extra), 32'd0);
    if (w && !exp_err) begin
      check($sformatf("%s we count", name), 32'(we_cnt), 32'd1);
      check($sformatf("%s we cycle", name), 32'(we_cyc), 32'(exp_lat - 1));
      check($sformatf("%s we addr", name), 32'(wa), 32'(a[16:2]));
      check($sformatf("%s we data", name), wdat, exp_word);
    end else begin
      check($sformatf("%s we count", name), 32'(we_cnt), 32'd0);
    end
  endtask

  typedef struct {
    logic        pk;
    logic [31:0] pk_val;
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
    int          lat;
    logic [31:0] word;
  } vec_t;

  vec_t vecs [17];

  initial begin
    logic m_err;
    logic [31:0] m_rd, m_word, r, a, wd;
    int m_lat;
    logic [8:0] rdy, rsp, wev;
    logic [31:0] rd_c6;
    int stray;

    vecs[0]  = '{1'b0, 32'h0,        1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        2, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 32'h0,        1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 3, 32'h0};
    vecs[2]  = '{1'b1, 32'h11223344, 1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h123456AA, 1'b0, 32'h0,        4, 32'h1122AA44};
    vecs[3]  = '{1'b0, 32'h0,        1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0,        1'b0, 32'hFFFFFFAA, 3, 32'h0};
    vecs[4]  = '{1'b0, 32'h0,        1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0,        1'b0, 32'h000000AA, 3, 32'h0};
    vecs[5]  = '{1'b1, 32'h11223344, 1'b1, SZ_HALF, 1'b0, 32'h12, 32'hCAFE8001, 1'b0, 32'h0,        4, 32'h80013344};
    vecs[6]  = '{1'b0, 32'h0,        1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0,        1'b0, 32'hFFFF8001, 3, 32'h0};
    vecs[7]  = '{1'b0, 32'h0,        1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0,        1'b0, 32'h00008001, 3, 32'h0};
    vecs[8]  = '{1'b0, 32'h0,        1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0,        1'b0, 32'hFFFFFF80, 3, 32'h0};
    vecs[9]  = '{1'b0, 32'h0,        1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0,        1'b0, 32'h00000044, 3, 32'h0};
    vecs[10] = '{1'b0, 32'h0,        1'b0, SZ_WORD, 1'b0, 32'h2,  32'h0,        1'b1, 32'h0,        1, 32'h0};
    vecs[11] = '{1'b0, 32'h0,        1'b0, SZ_HALF, 1'b0, 32'h1,  32'h0,        1'b1, 32'h0,        1, 32'h0};
    vecs[12] = '{1'b0, 32'h0,        1'b0, 2'b11,   1'b0, 32'h0,  32'h0,        1'b1, 32'h0,        1, 32'h0};
    vecs[13] = '{1'b0, 32'h0,        1'b0, SZ_WORD, 1'b0, 32'h0002_0000, 32'h0, 1'b1, 32'h0,        1, 32'h0};
    vecs[14] = '{1'b0, 32'h0,        1'b1, SZ_WORD, 1'b0, 32'h3,  32'h55555555, 1'b1, 32'h0,        1, 32'h0};
    vecs[15] = '{1'b0, 32'h0,        1'b1, SZ_HALF, 1'b0, 32'h16, 32'h00007FFF, 1'b0, 32'h0,        4, 32'h7FFF0000};
    vecs[16] = '{1'b0, 32'h0,        1'b0, SZ_HALF, 1'b0, 32'h16, 32'h0,        1'b0, 32'h00007FFF, 3, 32'h0};

    drive(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0);

    // Reset values
    repeat (2) @(negedge clock);
    check("reset req_ready", 32'(bus.req_ready), 32'd1);
    check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset resp_rdata", bus.resp_rdata, 32'h0);
    check("reset resp_error", 32'(bus.resp_error), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset mem_read_addr", 32'(mem_read_addr), 32'h0);
    check("reset mem_write_addr", 32'(mem_write_addr), 32'h0);
    check("reset mem_data", mem_data, 32'h0);
    reset = 1'b0;

    // Directed vectors
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].pk) poke(vecs[i].a, vecs[i].pk_val);
      model(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].wd, m_err, m_rd, m_lat, m_word);
      run_and_check($sformatf("vec%0d", i), vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a,
                    vecs[i].wd, vecs[i].err, vecs[i].rd, vecs[i].lat, vecs[i].word);
    end

    // Back-to-back sw then lw with req_valid held high
    model(1'b1, SZ_WORD, 1'b0, 32'h0, 32'h5, m_err, m_rd, m_lat, m_word);
    rdy = '0; rsp = '0; wev = '0; rd_c6 = 32'h0;
    @(negedge clock);
    drive(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h0, 32'h5);
    @(posedge clock);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (c == 1) drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
      if (c == 4) drive(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
      rdy[c] = bus.req_ready;
      rsp[c] = bus.resp_valid;
      wev[c] = mem_we;
      if (c == 6) rd_c6 = bus.resp_rdata;
    end
    check("b2b ready pattern", 32'(rdy), 32'h188);
    check("b2b resp pattern", 32'(rsp), 32'h044);
    check("b2b we pattern", 32'(wev), 32'h002);
    check("b2b load rdata", rd_c6, 32'h5);

    // Reset during RD_DATA of an sb; RAM must stay unmodified
    poke(32'h20, 32'h12345678);
    @(negedge clock);
    drive(1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h20, 32'hFF);
    @(posedge clock);
    @(negedge clock);
    drive(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0);
    check("abort busy before reset", 32'(bus.req_ready), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort req_ready", 32'(bus.req_ready), 32'd1);
    check("abort mem_we", 32'(mem_we), 32'd0);
    check("abort resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (bus.resp_valid || mem_we) stray++;
    end
    check("abort no response", 32'(stray), 32'd0);
    run_and_check("abort reload", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 1'b0, 32'h12345678, 3, 32'h0);

    // Random traffic against the reference model
    for (int i = 0; i < 150; i++) begin
      r  = $urandom;
      wd = $urandom;
      case (r[7:4])
        4'd0:    a = $urandom;
        4'd1:    a = 32'h0001_FFFC + {30'h0, r[9:8]};
        default: a = {26'h0, r[13:8]};
      endcase
      model(r[0], r[2:1], r[3], a, wd, m_err, m_rd, m_lat, m_word);
      run_and_check($sformatf("rand%0d", i), r[0], r[2:1], r[3], a, wd, m_err, m_rd, m_lat, m_word);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts processor load/store requests (byte address, size, sign) and drives the word-addressed synchronous data RAM.
- Handles sub-word stores by read-modify-write, because the RAM has only a whole-word write enable.
- Sits between the MEM pipeline stage and the data memory; one request in flight at a time.

Parameters:
- DATA_WIDTH, 32, RAM word width; must be 32.
- ADDR_WIDTH, 15, RAM word-address width; byte space = 2**(ADDR_WIDTH+2) bytes.

Ports:
- clock  in  1  single clock; RAM read_clock and write_clock are tied to it.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; request accepted on a clock edge with req_valid & req_ready.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: zero-extend when 1 (lbu/lhu), sign-extend when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_error  out  1  misaligned, out-of-range, or illegal size; qualified by resp_valid.
- mem_read_addr  out  ADDR_WIDTH  RAM read address.
- mem_write_addr  out  ADDR_WIDTH  RAM write address.
- mem_data  out  DATA_WIDTH  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_q  in  DATA_WIDTH  RAM registered read data; valid one cycle after the address is sampled.

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_we=0, all mem addresses and data=0, state=IDLE.
- Word address = req_addr[ADDR_WIDTH+1:2]. Byte lanes are little-endian: offset 0 maps to bits 7:0.
- Error checks, evaluated at acceptance:
  - halfword with addr[0]=1
  - word with addr[1:0]!=0
  - size=11
  - req_addr[31:ADDR_WIDTH+2] != 0
- FSM states: IDLE, RD_ISSUE, RD_DATA, WRITE, RESP. req_ready=1 only in IDLE.
- All request fields are captured into registers at acceptance. Later changes on the req_* inputs are ignored.
- Transitions (cycle 0 = acceptance cycle):
  - Error: IDLE->RESP. resp_valid and resp_error high in cycle 1. No RAM access and mem_we stays 0.
  - Load: IDLE->RD_ISSUE(c1, mem_read_addr driven) -> RD_DATA(c2, mem_q valid; lane extracted and extended, registered) -> RESP(c3, resp_valid=1, resp_rdata valid).
  - Word store: IDLE->WRITE(c1, mem_we=1, mem_data=wdata) -> RESP(c2).
  - Sub-word store: IDLE->RD_ISSUE(c1) -> RD_DATA(c2, merge wdata[7:0] or wdata[15:0] into mem_q at the offset lane, registered) -> WRITE(c3, mem_we=1) -> RESP(c4).
  - RESP->IDLE unconditionally. A new request may be accepted in the cycle after RESP.
- mem_we is a registered output, high for exactly one cycle per store and never in any other state. mem_write_addr equals mem_read_addr throughout an RMW sequence.
- resp_valid has no backpressure: it is a one-cycle pulse.
- Hazards: a write completes at the end of WRITE, before any subsequent read issue, so a store followed by a load returns the new data. There is no read-during-write overlap.
- Reset mid-operation: immediately forces IDLE and mem_we=0. An RMW interrupted before WRITE leaves RAM unmodified. No response is issued for the aborted request.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - FSM state enum
  - error-check function
- One sub-module, lsu_lane_mux (combinational):
  - load extraction with sign/zero extension
  - store merge of new bytes into the old word by size and offset
- The FSM and registers live in load_store_unit.

Test Plan:
1. Word store 0xDEADBEEF @0x10, then lw @0x10 -> mem_we pulse in c1 with mem_write_addr=4; lw resp_valid in c3 with rdata=0xDEADBEEF.
2. sb 0xAA @0x11 onto word 0x11223344 -> mem_data=0x1122AA44 written in c3; lb @0x11 -> 0xFFFFFFAA; lbu @0x11 -> 0x000000AA.
3. sh 0x8001 @0x12 onto 0x11223344 -> 0x80013344; lh @0x12 -> 0xFFFF8001; lhu -> 0x00008001.
4. lw @0x2, lh @0x1, size=11, addr 0x0002_0000 -> each gives resp_error=1 in c1, mem_we never asserted, rdata=0.
5. Back-to-back: sw 0x5 @0x0 then lw @0x0 with req_valid held high -> second request accepted in the cycle after RESP; rdata=0x5; req_ready low throughout busy states.
6. Assert reset during RD_DATA of sb @0x20 (word 0x12345678) -> req_ready=1 and mem_we=0 immediately, no resp_valid; subsequent lw @0x20 returns 0x12345678.
